lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter MASK_W, default 4, byte-strobe width (XLEN/8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports exu_valid input 1 and lsu_ready output 1, the upstream handshake.
REQ-006 SHALL have ports mem_op input 1, mem_wen input 1 and func3 input 3, the access kind and width.
REQ-007 SHALL have ports alu_res input XLEN (the effective address, or the pass-through result) and store_data input XLEN.
REQ-008 SHALL have ports lsu_valid output 1 and wbu_ready input 1, the downstream handshake.
REQ-009 SHALL have ports lsu_result output XLEN (the aligned load data or alu_res) and lsu_err output 1.
REQ-010 SHALL have ports mem_req_valid output 1, mem_req_ready input 1, mem_addr output XLEN, mem_we output 1, mem_wdata output XLEN and mem_wmask output MASK_W.
REQ-011 SHALL have ports mem_rvalid input 1 and mem_rdata input XLEN, the memory response.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-013 SHALL drive lsu_ready=1 only in IDLE and lsu_valid=1 only in DONE.
REQ-014 SHALL, in IDLE on exu_valid&&lsu_ready, register mem_op, mem_wen, func3, alu_res and store_data, then go to REQ if mem_op=1, else to DONE.
REQ-015 SHALL hold mem_req_valid=1 in REQ with mem_addr={alu_res[XLEN-1:2],2'b00}, and go to WAIT on mem_req_ready.
REQ-016 SHALL keep mem_addr, mem_we, mem_wdata and mem_wmask stable while mem_req_valid=1 and mem_req_ready=0.
REQ-017 SHALL, in WAIT on mem_rvalid, capture mem_rdata and go to DONE; mem_rvalid SHALL be ignored in every other state.
REQ-018 SHALL require a response for stores as well as loads; on a store response lsu_result=0.
REQ-019 SHALL, in DONE, hold lsu_valid and lsu_result stable until wbu_ready, then return to IDLE; there is no back-to-back accept in the same cycle.
REQ-020 SHALL achieve latency from accept to lsu_valid of 1 cycle for non-memory ops and 3 cycles minimum for memory ops (mem_req_ready and mem_rvalid each asserted on their first eligible cycle).
REQ-021 SHALL generate store mask by func3: 000 gives 4'b0001<<a, 001 gives 4'b0011<<a, 010 gives 4'b1111, where a=alu_res[1:0]; mem_wdata SHALL be store_data<<(8*a).
REQ-022 SHALL assert mem_we=0 and mem_wmask=0 for loads.
REQ-023 SHALL extract load data by func3: 000 lb sign-extended, 001 lh sign-extended, 010 lw, 100 lbu zero-extended, 101 lhu zero-extended, each using byte lane a; any other func3 SHALL give lsu_result=0.
REQ-024 SHALL, for a half-word with a=01 or 11 and without the check macro, select rdata[15:0] for a=01 and rdata[31:16] for a=11 (truncated lane, no fault).
REQ-025 SHALL give lsu_result=alu_res unchanged for non-memory ops.
REQ-026 SHALL hold lsu_err=0 except as stated in REQ-030.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, lsu_valid=0, mem_req_valid=0, lsu_result=0, lsu_err=0 and all captured registers to 0; lsu_ready SHALL be 0 while rst=1.
REQ-028 SHALL, on rst asserted in REQ or WAIT, abandon the access with no retry, and a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-029 SHALL compile in the misalignment check only under macro LSU_MISALIGN_CHECK_EN.
REQ-030 SHALL, with LSU_MISALIGN_CHECK_EN defined, send a misaligned access (lh/lhu/sh with a[0]=1, or lw/sw with a!=0) from IDLE directly to DONE with lsu_err=1, lsu_result=alu_res and no memory request issued.
REQ-031 SHALL, without LSU_MISALIGN_CHECK_EN, tie lsu_err to 0 and issue every access per REQ-021/REQ-024.

Structure
REQ-032 SHALL place the FSM state enum, the func3 width codes (LB, LH, LW, LBU, LHU) and the mask constants in shared package core_pkg.
REQ-033 SHALL place the load align/extend logic in one combinational sub-module lsu_align; all other logic SHALL reside in lsu.

Verification
REQ-034 SHALL verify: lb, alu_res=0x8000_0003, mem_rdata=0x80AA_BBCC -> lsu_result=0xFFFF_FF80, mem_addr=0x8000_0000.
REQ-035 SHALL verify: sh, alu_res=0x1002, store_data=0x0000_BEEF -> mem_wmask=4'b1100, mem_wdata=0xBEEF_0000, mem_we=1.
REQ-036 SHALL verify: mem_req_ready low for 5 cycles, then high -> request fields unchanged over all 6 cycles, one transfer only.
REQ-037 SHALL verify: non-memory op, alu_res=0x1234, wbu_ready low for 3 cycles -> lsu_valid high 1 cycle after accept, held 4 cycles, lsu_ready=0 throughout.
REQ-038 SHALL verify: rst pulsed in WAIT, then mem_rvalid=1 -> state IDLE, lsu_valid stays 0.
REQ-039 SHALL verify: with LSU_MISALIGN_CHECK_EN, lw at 0x1001 -> lsu_err=1 one cycle after accept, mem_req_valid never asserted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared LSU definitions: FSM state encoding, func3 width codes, store byte masks
// and the alignment predicate.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Stores share the load codes for width (sb=LB, sh=LH, sw=LW).
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            LH, LHU: misaligned = a[0];
            LW:      misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data lane select and sign/zero extension. Half-words at odd offsets take
// the half containing the addressed byte's word half (truncated lane).
module lsu_align import core_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      func3_i,
    input  logic [1:0]      a_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{a_i, 3'b000} +: 8];
        half_lane = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (func3_i)
            LB:      data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LH:      data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
            LW:      data_o = rdata_i;
            LBU:     data_o = {{(XLEN-8){1'b0}}, byte_lane};
            LHU:     data_o = {{(XLEN-16){1'b0}}, half_lane};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op, issues at most one memory request, returns the
// result downstream. Misalignment faulting is built only with LSU_MISALIGN_CHECK_EN.
module lsu import core_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              lsu_ready,
    input  logic              mem_op,
    input  logic              mem_wen,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   alu_res,
    input  logic [XLEN-1:0]   store_data,
    output logic              lsu_valid,
    input  logic              wbu_ready,
    output logic [XLEN-1:0]   lsu_result,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output lsu_state_e        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and its payload unchanged until that edge.
    lsu_state_e      state_q;
    logic            mem_op_q, wen_q;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] addr_q, sdata_q, result_q;
    logic [XLEN-1:0] load_data;
    logic [MASK_W-1:0] mask;

    lsu_align #(.XLEN(XLEN)) u_align (
        .rdata_i (mem_rdata),
        .func3_i (func3_q),
        .a_i     (addr_q[1:0]),
        .data_o  (load_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    assign lsu_err = err_q;
`else
    assign lsu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mem_op_q <= 1'b0;
            wen_q    <= 1'b0;
            func3_q  <= 3'b000;
            addr_q   <= '0;
            sdata_q  <= '0;
            result_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (exu_valid) begin
                    mem_op_q <= mem_op;
                    wen_q    <= mem_wen;
                    func3_q  <= func3;
                    addr_q   <= alu_res;
                    sdata_q  <= store_data;
`ifdef LSU_MISALIGN_CHECK_EN
                    err_q    <= 1'b0;
`endif
                    if (!mem_op) begin
                        result_q <= alu_res;
                        state_q  <= S_DONE;
                    end
`ifdef LSU_MISALIGN_CHECK_EN
                    else if (misaligned(func3, alu_res[1:0])) begin
                        result_q <= alu_res;
                        err_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end
`endif
                    else begin
                        result_q <= '0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: if (mem_req_ready) state_q <= S_WAIT;
                S_WAIT: if (mem_rvalid) begin
                    result_q <= wen_q ? '0 : load_data;
                    state_q  <= S_DONE;
                end
                S_DONE: if (wbu_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (func3_q)
            LB:      mask = MASK_W'(MASK_BYTE) << addr_q[1:0];
            LH:      mask = MASK_W'(MASK_HALF) << addr_q[1:0];
            LW:      mask = MASK_W'(MASK_WORD);
            default: mask = '0;
        endcase
    end

    assign lsu_ready     = (state_q == S_IDLE) && !rst;
    assign lsu_valid     = (state_q == S_DONE);
    assign lsu_result    = result_q;
    assign mem_req_valid = (state_q == S_REQ) && mem_op_q;
    assign mem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign mem_we        = wen_q;
    assign mem_wdata     = sdata_q << {addr_q[1:0], 3'b000};
    assign mem_wmask     = wen_q ? mask : '0;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu; expected results go through a scoreboard queue.
// Build with LSU_MISALIGN_CHECK_EN to exercise the misalignment fault path.
module tb_lsu;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int MASK_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exu_valid = 1'b0, mem_op = 1'b0, mem_wen = 1'b0;
    logic [2:0] func3 = 3'b000;
    logic [XLEN-1:0] alu_res = '0, store_data = '0, mem_rdata = '0;
    logic wbu_ready = 1'b0, mem_req_ready = 1'b0, mem_rvalid = 1'b0;
    logic lsu_ready, lsu_valid, lsu_err, mem_req_valid, mem_we;
    logic [XLEN-1:0] lsu_result, mem_addr, mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    lsu_state_e dbg_state;

    lsu #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .mem_op(mem_op), .mem_wen(mem_wen), .func3(func3), .alu_res(alu_res),
        .store_data(store_data), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .lsu_result(lsu_result), .lsu_err(lsu_err), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int reqv_cnt = 0;
    logic [XLEN-1:0] exp_q[$];
    logic exp_err_q[$];

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) hs_cnt++;
        if (mem_req_valid) reqv_cnt++;
    end

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] a, logic [31:0] d);
        logic [31:0] bs = d >> (8 * a);
        logic [31:0] hs = a[1] ? (d >> 16) : d;
        case (f3)
            3'b000:  return {{24{bs[7]}}, bs[7:0]};
            3'b001:  return {{16{hs[15]}}, hs[15:0]};
            3'b010:  return d;
            3'b100:  return {24'b0, bs[7:0]};
            3'b101:  return {16'b0, hs[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic accept(input logic op, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd);
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: lsu_ready=%b required 1", lsu_ready);
        end
        exu_valid = 1'b1; mem_op = op; mem_wen = wen; func3 = f3;
        alu_res = addr; store_data = sd;
        tick();
        exu_valid = 1'b0;
    endtask

    task automatic mem_respond(input int delay, input logic [31:0] rdata);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < delay; i++) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        logic [31:0] exp;
        logic exp_err;
        while (lsu_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (lsu_valid !== 1'b1) begin
            errors++; $display("FAIL drain_timeout: lsu_valid=%b required 1", lsu_valid);
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL drain_unexpected: result=%h with empty scoreboard", lsu_result);
        end else begin
            exp = exp_q.pop_front();
            exp_err = exp_err_q.pop_front();
            checks++;
            if (lsu_result !== exp) begin
                errors++; $display("FAIL drain_result: got %h required %h", lsu_result, exp);
            end
            checks++;
            if (lsu_err !== exp_err) begin
                errors++; $display("FAIL drain_err: got %b required %b", lsu_err, exp_err);
            end
            wbu_ready = 1'b1;
            tick();
            wbu_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (dbg_state !== S_IDLE || lsu_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
            lsu_result !== 32'h0 || lsu_err !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d valid=%b reqv=%b result=%h err=%b ready=%b required 0,0,0,0,0,0",
                     dbg_state, lsu_valid, mem_req_valid, lsu_result, lsu_err, lsu_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", lsu_ready);
        end
    endtask

    task automatic test_lb();
        exp_q.push_back(32'hFFFF_FF80); exp_err_q.push_back(1'b0);
        accept(1'b1, 1'b0, LB, 32'h8000_0003, 32'h0);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin
            errors++;
            $display("FAIL lb_request: reqv=%b addr=%h we=%b mask=%b required 1 80000000 0 0000",
                     mem_req_valid, mem_addr, mem_we, mem_wmask);
        end
        mem_respond(0, 32'h80AA_BBCC);
        drain();
    endtask

    task automatic test_sh();
        exp_q.push_back(32'h0); exp_err_q.push_back(1'b0);
        accept(1'b1, 1'b1, LH, 32'h0000_1002, 32'h0000_BEEF);
        checks++;
        if (mem_wmask !== 4'b1100 || mem_wdata !== 32'hBEEF_0000 || mem_we !== 1'b1 || mem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL sh_request: mask=%b wdata=%h we=%b addr=%h required 1100 beef0000 1 00001000",
                     mem_wmask, mem_wdata, mem_we, mem_addr);
        end
        mem_respond(0, 32'h5555_AAAA);
        drain();
    endtask

    task automatic test_backpressure();
        int hs0;
        hs0 = hs_cnt;
        exp_q.push_back(32'h0); exp_err_q.push_back(1'b0);
        accept(1'b1, 1'b1, LW, 32'h0000_2000, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b1111) begin
                errors++;
                $display("FAIL bp_stable cycle %0d: reqv=%b addr=%h we=%b wdata=%h mask=%b required 1 00002000 1 deadbeef 1111",
                         i, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || hs_cnt - hs0 !== 1) begin
            errors++;
            $display("FAIL bp_single_transfer: reqv=%b transfers=%0d required 0 and 1", mem_req_valid, hs_cnt - hs0);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_rvalid = 1'b0;
        drain();
    endtask

    task automatic test_nonmem_stall();
        logic [31:0] exp;
        exp_q.push_back(32'h0000_1234); exp_err_q.push_back(1'b0);
        accept(1'b0, 1'b0, LW, 32'h0000_1234, 32'h0);
        exp = exp_q.pop_front();
        void'(exp_err_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            wbu_ready = (i == 3);
            checks++;
            if (lsu_valid !== 1'b1 || lsu_result !== exp || lsu_ready !== 1'b0 || lsu_err !== 1'b0) begin
                errors++;
                $display("FAIL nonmem_hold cycle %0d: valid=%b result=%h ready=%b err=%b required 1 %h 0 0",
                         i, lsu_valid, lsu_result, lsu_ready, lsu_err, exp);
            end
            tick();
        end
        wbu_ready = 1'b0;
        checks++;
        if (lsu_valid !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL nonmem_release: valid=%b ready=%b required 0 1", lsu_valid, lsu_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        accept(1'b1, 1'b0, LW, 32'h0000_3000, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (dbg_state !== S_WAIT) begin
            errors++; $display("FAIL rstwait_in_wait: state=%0d required %0d", dbg_state, S_WAIT);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dbg_state !== S_IDLE || lsu_ready !== 1'b0 || lsu_valid !== 1'b0 || lsu_result !== 32'h0) begin
            errors++;
            $display("FAIL rstwait_during_rst: state=%0d ready=%b valid=%b result=%h required 0 0 0 0",
                     dbg_state, lsu_ready, lsu_valid, lsu_result);
        end
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dbg_state !== S_IDLE || lsu_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstwait_late_rvalid cycle %0d: state=%0d valid=%b reqv=%b required 0 0 0",
                         i, dbg_state, lsu_valid, mem_req_valid);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h11); exp_err_q.push_back(1'b0);
        exp_q.push_back(32'h22); exp_err_q.push_back(1'b0);
        accept(1'b0, 1'b0, LW, 32'h11, 32'h0);
        exu_valid = 1'b1; alu_res = 32'h22;
        checks++;
        if (lsu_valid !== 1'b1 || lsu_ready !== 1'b0 || lsu_result !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_first: valid=%b ready=%b result=%h required 1 0 %h", lsu_valid, lsu_ready, lsu_result, exp_q[0]);
        end
        void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
        wbu_ready = 1'b1;
        tick();
        wbu_ready = 1'b0;
        checks++;
        if (lsu_valid !== 1'b0 || lsu_ready !== 1'b1 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL b2b_gap: valid=%b ready=%b state=%0d required 0 1 0", lsu_valid, lsu_ready, dbg_state);
        end
        tick();
        exu_valid = 1'b0;
        drain();
    endtask

`ifdef LSU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        int rv0;
        rv0 = reqv_cnt;
        exp_q.push_back(32'h0000_1001); exp_err_q.push_back(1'b1);
        accept(1'b1, 1'b0, LW, 32'h0000_1001, 32'h0);
        checks++;
        if (lsu_err !== 1'b1 || lsu_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_fault: err=%b valid=%b reqv=%b required 1 1 0", lsu_err, lsu_valid, mem_req_valid);
        end
        drain();
        checks++;
        if (reqv_cnt != rv0) begin
            errors++; $display("FAIL misalign_no_request: req cycles=%0d required 0", reqv_cnt - rv0);
        end
    endtask
`else
    task automatic test_truncated_lane();
        exp_q.push_back(32'hFFFF_F678); exp_err_q.push_back(1'b0);
        accept(1'b1, 1'b0, LH, 32'h0000_4001, 32'h0);
        mem_respond(1, 32'h1234_F678);
        drain();
        exp_q.push_back(32'h0000_89AB); exp_err_q.push_back(1'b0);
        accept(1'b1, 1'b0, LHU, 32'h0000_4003, 32'h0);
        mem_respond(0, 32'h89AB_0000);
        drain();
    endtask
`endif

    task automatic test_random();
        logic [2:0] f3_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int it = 0; it < 24; it++) begin
            logic [2:0] f3;
            logic [31:0] addr, sd, rd, exp_wdata;
            logic [3:0] exp_mask;
            logic wen;
            f3 = f3_tab[$urandom_range(0, 6)];
            addr = $urandom; sd = $urandom; rd = $urandom;
            wen = (f3 <= 3'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            if (f3 == 3'd1 || f3 == 3'd5) addr[0] = 1'b0;
            if (f3 == 3'd2) addr[1:0] = 2'b00;
`endif
            exp_mask = (f3 == 3'd0) ? (4'b0001 << addr[1:0]) :
                       (f3 == 3'd1) ? (4'b0011 << addr[1:0]) : 4'b1111;
            exp_wdata = sd << (8 * addr[1:0]);
            exp_q.push_back(wen ? 32'h0 : model_load(f3, addr[1:0], rd));
            exp_err_q.push_back(1'b0);
            accept(1'b1, wen, f3, addr, sd);
            if (wen) begin
                checks++;
                if (mem_wmask !== exp_mask || mem_wdata !== exp_wdata || mem_we !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_store %0d: mask=%b wdata=%h we=%b required %b %h 1",
                             it, mem_wmask, mem_wdata, mem_we, exp_mask, exp_wdata);
                end
            end
            mem_respond($urandom_range(0, 2), rd);
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_backpressure();
        test_nonmem_stall();
        test_reset_in_wait();
        test_back_to_back();
`ifdef LSU_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_truncated_lane();
`endif
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
